// File: rtl/mcb_port_bram.sv
// Block-RAM backed responder for the DDR user port (cmd/wr/rd FIFOs).
// Lets the DMA engine run against on-chip memory when no external DRAM is present.

module mcb_sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter bit SHOW_AHEAD = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_reg, rptr_reg;
  logic [AW:0]      count_reg, count_next;
  logic             push_ok, pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_reg] <= din;
  end

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop_ok) count_next = count_reg + (AW+1)'(1);
    else if (!push_ok && pop_ok) count_next = count_reg - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push_ok) wptr_reg <= wptr_reg + AW'(1);
      if (pop_ok)  rptr_reg <= rptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  generate
    if (SHOW_AHEAD) begin : g_show_ahead
      assign dout = mem[rptr_reg];
    end else begin : g_reg_out
      // Popped word is held until the next accepted pop.
      logic [WIDTH-1:0] dout_reg;
      always_ff @(posedge clk) begin
        if (!reset_n)    dout_reg <= '0;
        else if (pop_ok) dout_reg <= mem[rptr_reg];
      end
      assign dout = dout_reg;
    end
  endgenerate
endmodule

module mcb_port_bram #(
  parameter int ADDR_WIDTH   = 10,
  parameter int WR_DEPTH     = 64,
  parameter int RD_DEPTH     = 64,
  parameter int CMD_DEPTH    = 4,
  parameter int CALIB_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  output logic                        calib_done,
  input  logic                        cmd_en,
  input  logic [2:0]                  cmd_instr,
  input  logic [29:0]                 cmd_byte_addr,
  input  logic [5:0]                  cmd_bl,
  output logic                        cmd_full,
  output logic                        cmd_empty,
  input  logic                        wr_en,
  input  logic [31:0]                 wr_data,
  input  logic [3:0]                  wr_mask,
  output logic                        wr_full,
  output logic [$clog2(WR_DEPTH):0]   wr_count,
  input  logic                        rd_en,
  output logic [31:0]                 rd_data,
  output logic                        rd_empty,
  output logic [$clog2(RD_DEPTH):0]   rd_count
);
  localparam int CMD_W = 3 + ADDR_WIDTH + 6;
  localparam int CCW   = $clog2(CALIB_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [6:0]            rem_reg, rem_next;
  logic                  rd_valid_reg;
  logic [CCW-1:0]        calib_cnt_reg;
  logic                  calib_done_reg;

  logic [CMD_W-1:0]      cmd_head;
  logic [35:0]           wr_head;
  logic                  cmd_pop, wr_pop, wr_empty;
  logic                  bram_we, bram_re, lane_we;
  logic [31:0]           bram_q;
  logic [2:0]            head_instr;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [5:0]            head_bl;
  logic [31:0]           rd_free, rd_need;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{cmd_byte_addr[29:ADDR_WIDTH+2], cmd_byte_addr[1:0]};
  assign calib_done = calib_done_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      calib_cnt_reg  <= '0;
      calib_done_reg <= 1'b0;
    end else if (!calib_done_reg) begin
      calib_cnt_reg <= calib_cnt_reg + CCW'(1);
      if (calib_cnt_reg == CCW'(CALIB_CYCLES - 1)) calib_done_reg <= 1'b1;
    end
  end

  mcb_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH), .SHOW_AHEAD(1'b1)) u_cmd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cmd_en),
    .din     ({cmd_instr, cmd_byte_addr[ADDR_WIDTH+1:2], cmd_bl}),
    .pop     (cmd_pop),
    .dout    (cmd_head),
    .full    (cmd_full),
    .empty   (cmd_empty),
    .count   ()
  );

  mcb_sync_fifo #(.WIDTH(36), .DEPTH(WR_DEPTH), .SHOW_AHEAD(1'b1)) u_wr_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_en),
    .din     ({wr_data, wr_mask}),
    .pop     (wr_pop),
    .dout    (wr_head),
    .full    (wr_full),
    .empty   (wr_empty),
    .count   (wr_count)
  );

  mcb_sync_fifo #(.WIDTH(32), .DEPTH(RD_DEPTH), .SHOW_AHEAD(1'b0)) u_rd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rd_valid_reg),
    .din     (bram_q),
    .pop     (rd_en),
    .dout    (rd_data),
    .full    (),
    .empty   (rd_empty),
    .count   (rd_count)
  );

  assign head_instr = cmd_head[CMD_W-1 -: 3];
  assign head_addr  = cmd_head[6 +: ADDR_WIDTH];
  assign head_bl    = cmd_head[5:0];
  // Free space counts the word still in the BRAM output register as taken.
  assign rd_free    = 32'(RD_DEPTH) - 32'(rd_count) - 32'(rd_valid_reg);
  assign rd_need    = 32'(head_bl) + 32'd1;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    rem_next   = rem_reg;
    cmd_pop    = 1'b0;
    wr_pop     = 1'b0;
    bram_we    = 1'b0;
    bram_re    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (calib_done_reg && !cmd_empty) begin
          case (head_instr)
            3'b000: begin
              cmd_pop    = 1'b1;
              addr_next  = head_addr;
              rem_next   = 7'(head_bl) + 7'd1;
              state_next = WRITE;
            end
            3'b001: begin
              // Read waits at the head until its whole burst fits in the rd FIFO.
              if (rd_free >= rd_need) begin
                cmd_pop    = 1'b1;
                addr_next  = head_addr;
                rem_next   = 7'(head_bl) + 7'd1;
                state_next = READ;
              end
            end
            default: cmd_pop = 1'b1;
          endcase
        end
      end
      WRITE: begin
        if (!wr_empty) begin
          wr_pop    = 1'b1;
          bram_we   = 1'b1;
          addr_next = addr_reg + ADDR_WIDTH'(1);
          rem_next  = rem_reg - 7'd1;
          if (rem_reg == 7'd1) state_next = IDLE;
        end
      end
      READ: begin
        bram_re   = 1'b1;
        addr_next = addr_reg + ADDR_WIDTH'(1);
        rem_next  = rem_reg - 7'd1;
        if (rem_reg == 7'd1) state_next = DRAIN;
      end
      DRAIN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      rem_reg      <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      rem_reg      <= rem_next;
      rd_valid_reg <= bram_re;
    end
  end

  // Memory keeps its contents through reset, so only block the write strobe.
  assign lane_we = bram_we & reset_n;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [2**ADDR_WIDTH];
      logic [7:0] lane_q_reg;
      always_ff @(posedge clk) begin
        if (lane_we && !wr_head[gi]) lane_mem[addr_reg] <= wr_head[4 + gi*8 +: 8];
        if (bram_re) lane_q_reg <= lane_mem[addr_reg];
      end
      assign bram_q[gi*8 +: 8] = lane_q_reg;
    end
  endgenerate
endmodule

// File: tb/tb_mcb_port_bram.sv
// Directed bench for mcb_port_bram: calibration, bursts, masking, wrap,
// read backpressure and command/write FIFO stalls.
module tb_mcb_port_bram;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        calib_done;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [29:0] cmd_byte_addr;
  logic [5:0]  cmd_bl;
  logic        cmd_full, cmd_empty;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        wr_full;
  logic [6:0]  wr_count;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_empty;
  logic [6:0]  rd_count;

  int n_pass  = 0;
  int n_total = 0;

  mcb_port_bram dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .calib_done    (calib_done),
    .cmd_en        (cmd_en),
    .cmd_instr     (cmd_instr),
    .cmd_byte_addr (cmd_byte_addr),
    .cmd_bl        (cmd_bl),
    .cmd_full      (cmd_full),
    .cmd_empty     (cmd_empty),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .wr_mask       (wr_mask),
    .wr_full       (wr_full),
    .wr_count      (wr_count),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_empty      (rd_empty),
    .rd_count      (rd_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic push_cmd(input logic [2:0] instr, input logic [29:0] addr, input logic [5:0] bl);
    cmd_en = 1'b1; cmd_instr = instr; cmd_byte_addr = addr; cmd_bl = bl;
    step();
    cmd_en = 1'b0;
    $display("cmd instr=%0d byte_addr=0x%08h bl=%0d", instr, addr, bl);
  endtask

  task automatic push_wr(input logic [31:0] data, input logic [3:0] mask);
    wr_en = 1'b1; wr_data = data; wr_mask = mask;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pop_rd(output logic [31:0] data);
    int wait_cnt;
    wait_cnt = 0;
    while (rd_empty && wait_cnt < 200) begin
      step();
      wait_cnt++;
    end
    if (wait_cnt >= 200) chk("rd_wait_timeout", 32'(rd_empty), 32'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    data = rd_data;
    $display("rd pop data=0x%08h count_after=%0d", data, rd_count);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    steps(3);
    reset_n = 1'b1;
  endtask

  logic [31:0] d;
  int          wait_cnt;

  initial begin
    reset_n = 1'b0; cmd_en = 1'b0; cmd_instr = '0; cmd_byte_addr = '0; cmd_bl = '0;
    wr_en = 1'b0; wr_data = '0; wr_mask = '0; rd_en = 1'b0;
    steps(3);
    chk("rst_calib_done", 32'(calib_done), 32'd0);
    chk("rst_cmd_full",   32'(cmd_full),   32'd0);
    chk("rst_cmd_empty",  32'(cmd_empty),  32'd1);
    chk("rst_wr_full",    32'(wr_full),    32'd0);
    chk("rst_wr_count",   32'(wr_count),   32'd0);
    chk("rst_rd_empty",   32'(rd_empty),   32'd1);
    chk("rst_rd_count",   32'(rd_count),   32'd0);
    chk("rst_rd_data",    rd_data,         32'd0);

    // Calibration: 16 edges after reset release
    reset_n = 1'b1;
    steps(15);
    chk("calib_early", 32'(calib_done), 32'd0);
    step();
    chk("calib_on_time", 32'(calib_done), 32'd1);
    steps(3);
    chk("idle_cmd_empty", 32'(cmd_empty), 32'd1);
    chk("idle_rd_empty",  32'(rd_empty),  32'd1);

    // Five no-op commands before calibration: the fifth is dropped
    do_reset();
    cmd_en = 1'b1; cmd_instr = 3'b111; cmd_byte_addr = '0; cmd_bl = '0;
    steps(5);
    cmd_en = 1'b0;
    chk("cmd_full_after5", 32'(cmd_full),  32'd1);
    chk("cmd_nonempty",    32'(cmd_empty), 32'd0);
    wait_cnt = 0;
    while (!calib_done && wait_cnt < 40) begin step(); wait_cnt++; end
    chk("calib_reached", 32'(calib_done), 32'd1);
    steps(3);
    chk("noop_3_left1", 32'(cmd_empty), 32'd0);
    step();
    chk("noop_drained4", 32'(cmd_empty), 32'd1);

    // 32-word write then read-back
    for (int i = 0; i < 32; i++) push_wr(32'h100 + 32'(i), 4'b0000);
    chk("wr_count_32", 32'(wr_count), 32'd32);
    push_cmd(3'b000, 30'h0, 6'd31);
    steps(40);
    chk("wr_consumed", 32'(wr_count), 32'd0);
    push_cmd(3'b001, 30'h0, 6'd31);
    steps(2);
    chk("rd_lat_early", 32'(rd_empty), 32'd1);
    steps(2);
    chk("rd_lat_ready", 32'(rd_empty), 32'd0);
    steps(40);
    chk("rd_count_peak32", 32'(rd_count), 32'd32);
    for (int i = 0; i < 32; i++) begin
      pop_rd(d);
      chk($sformatf("burst_word%0d", i), d, 32'h100 + 32'(i));
    end
    chk("burst_rd_empty", 32'(rd_empty), 32'd1);

    // Masked write: bytes 0 and 2 keep their old value
    push_wr(32'hFFFF_FFFF, 4'b0000);
    push_cmd(3'b000, 30'h0, 6'd0);
    push_wr(32'h1234_5678, 4'b0101);
    push_cmd(3'b000, 30'h0, 6'd0);
    push_cmd(3'b001, 30'h0, 6'd0);
    pop_rd(d);
    chk("masked_word", d, 32'h12FF_56FF);

    // Wrap: words 1022, 1023, 0, 1
    push_wr(32'hAAAA_0001, 4'b0000);
    push_wr(32'hBBBB_0002, 4'b0000);
    push_wr(32'hCCCC_0003, 4'b0000);
    push_wr(32'hDDDD_0004, 4'b0000);
    push_cmd(3'b000, 30'hFF8, 6'd3);
    push_cmd(3'b001, 30'h0, 6'd1);
    pop_rd(d); chk("wrap_rd0_C", d, 32'hCCCC_0003);
    pop_rd(d); chk("wrap_rd1_D", d, 32'hDDDD_0004);
    push_cmd(3'b001, 30'hFF8, 6'd3);
    pop_rd(d); chk("wrap_A", d, 32'hAAAA_0001);
    pop_rd(d); chk("wrap_B", d, 32'hBBBB_0002);
    pop_rd(d); chk("wrap_C", d, 32'hCCCC_0003);
    pop_rd(d); chk("wrap_D", d, 32'hDDDD_0004);
    push_cmd(3'b001, 30'h1000, 6'd0);
    pop_rd(d); chk("high_addr_ignored", d, 32'hCCCC_0003);

    // Backpressure: 56 words queued, a 16-word read must wait
    push_cmd(3'b001, 30'h0, 6'd31);
    push_cmd(3'b001, 30'h0, 6'd23);
    steps(70);
    chk("bp_fill56", 32'(rd_count), 32'd56);
    push_cmd(3'b001, 30'h40, 6'd15);
    steps(10);
    chk("bp_held_cmd", 32'(cmd_empty), 32'd0);
    chk("bp_held_count", 32'(rd_count), 32'd56);
    for (int i = 0; i < 8; i++) pop_rd(d);
    steps(30);
    chk("bp_started", 32'(cmd_empty), 32'd1);
    chk("bp_count64", 32'(rd_count), 32'd64);
    for (int i = 0; i < 48; i++) pop_rd(d);
    for (int i = 0; i < 16; i++) begin
      pop_rd(d);
      chk($sformatf("bp_word%0d", i), d, 32'h110 + 32'(i));
    end
    chk("bp_rd_empty", 32'(rd_empty), 32'd1);

    // Write stall: 10 of 32 words present, then the rest
    push_cmd(3'b000, 30'h200, 6'd31);
    for (int i = 0; i < 10; i++) push_wr(32'h2000 + 32'(i), 4'b0000);
    push_cmd(3'b001, 30'h200, 6'd0);
    steps(20);
    chk("stall_wr_drained", 32'(wr_count), 32'd0);
    chk("stall_cmd_waiting", 32'(cmd_empty), 32'd0);
    chk("stall_no_read", 32'(rd_empty), 32'd1);
    for (int i = 10; i < 32; i++) push_wr(32'h2000 + 32'(i), 4'b0000);
    steps(30);
    chk("stall_cmd_done", 32'(cmd_empty), 32'd1);
    pop_rd(d); chk("stall_first", d, 32'h2000);
    push_cmd(3'b001, 30'h27C, 6'd0);
    pop_rd(d); chk("stall_last", d, 32'h201F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
